instr_issuer: RTL and testbench

- Initiator side of the processor instruction interface. It buffers a short program of 16-bit instructions.
- On `start` it presents one instruction at a time to the processor control unit on `instruction`, with `Run` asserted, and holds it until the control unit returns `Done`. It then advances to the next instruction.
- It checks opcodes, enforces a per-instruction completion timeout, and reports progress and errors. It sits between the program loader/testbench and the control FSM.

---
 rtl/instr_issuer.sv | 179 +++++++++++++++++
 tb/tb_instr_issuer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issuer.sv
// Instruction issuer: buffers a short program and hands it one word at a time to the control unit.
// Build macro INSTR_ISSUER_STEP_EN adds a `step` input and a STALL state for single-stepping.
module instr_issuer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 8
) (
  input  logic          clock,
  input  logic          Rest,
  input  logic          load_en,
  input  logic [15:0]   load_data,
  input  logic          clear,
  input  logic          start,
  input  logic          abort,
  input  logic          Done,
`ifdef INSTR_ISSUER_STEP_EN
  input  logic          step,
`endif
  output logic [15:0]   instruction,
  output logic          Run,
  output logic          busy,
  output logic          finished,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW-1:0] pc,
  output logic [AW:0]   prog_len,
  output logic [2:0]    o_dbg_state
);
  // Handshake: Run is the valid and instruction is stable while it is high; Done is a one-cycle
  // completion strobe that only counts in ISSUE, and Run is low the cycle after Done is sampled.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] T_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_ADV    = 3'd3,
    S_FINISH = 3'd4
`ifdef INSTR_ISSUER_STEP_EN
    , S_STALL = 3'd5
`endif
  } state_t;

  state_t        r_state;
  logic [15:0]   r_buf [DEPTH];
  logic [15:0]   r_instr;
  logic          r_run;
  logic          r_busy;
  logic          r_finished;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [CW-1:0] r_tcnt;

  logic          w_loadable;
  logic          w_wr_en;
  logic          w_last;
  logic [15:0]   w_cur;

  assign w_loadable = (r_state == S_IDLE) || (r_state == S_FINISH);
  assign w_wr_en    = !Rest && w_loadable && load_en && !clear && (r_len != LEN_FULL);
  assign w_last     = ({1'b0, r_pc} == (r_len - 1'b1));
  assign w_cur      = r_buf[r_pc];

  // Buffer contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_buf[r_len[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (Rest) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_pc       <= '0;
      r_len      <= '0;
      r_tcnt     <= '0;
    end else if (abort && r_busy) begin
      // Abort beats Done and any pending check; pc and err keep their values.
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_FINISH: begin
          if (clear) begin
            r_len      <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_finished <= 1'b0;
          end else if (load_en) begin
            if (r_len == LEN_FULL) begin
              r_err      <= 1'b1;
              r_err_code <= 2'b11;
            end else begin
              r_len <= r_len + 1'b1;
            end
          end else if (start && !r_err) begin
            if (r_len == '0) begin
              r_state    <= S_FINISH;
              r_finished <= 1'b1;
            end else begin
              r_pc       <= '0;
              r_finished <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          r_instr <= w_cur;
          if (w_cur[15]) begin
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_run   <= 1'b1;
            r_tcnt  <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (Done) begin
            r_run  <= 1'b0;
            r_tcnt <= '0;
            if (w_last) begin
              r_finished <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_FINISH;
            end else begin
              r_pc <= r_pc + 1'b1;
`ifdef INSTR_ISSUER_STEP_EN
              r_state <= S_STALL;
`else
              r_state <= S_ADV;
`endif
            end
          end else if (r_tcnt == T_LAST) begin
            r_run      <= 1'b0;
            r_tcnt     <= '0;
            r_err      <= 1'b1;
            r_err_code <= 2'b10;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        // One idle cycle after Done gives the control unit a Run-low gap before the next CHECK.
        S_ADV: r_state <= S_CHECK;
`ifdef INSTR_ISSUER_STEP_EN
        S_STALL: begin
          if (step) r_state <= S_CHECK;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instruction = r_instr;
  assign Run         = r_run;
  assign busy        = r_busy;
  assign finished    = r_finished;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign pc          = r_pc;
  assign prog_len    = r_len;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: directed cases plus randomized programs, checked by an issue scoreboard.
module tb_instr_issuer;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int TIMEOUT   = 8;
  localparam int STEP_WAIT = 3;
`ifdef INSTR_ISSUER_STEP_EN
  localparam int GAP = STEP_WAIT + 2;
`else
  localparam int GAP = 3;
`endif

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  hi_len;
    logic        first;
    logic        chk_len;
  } exp_t;

  logic          clock = 1'b0;
  logic          Rest = 1'b1;
  logic          load_en = 1'b0;
  logic [15:0]   load_data = '0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          abort;
  logic          Done;
  logic [15:0]   instruction;
  logic          Run;
  logic          busy;
  logic          finished;
  logic          err;
  logic [1:0]    err_code;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic [2:0]    dbg_state;
`ifdef INSTR_ISSUER_STEP_EN
  logic          step;
`endif

  instr_issuer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .Rest(Rest), .load_en(load_en), .load_data(load_data), .clear(clear),
    .start(start), .abort(abort), .Done(Done),
`ifdef INSTR_ISSUER_STEP_EN
    .step(step),
`endif
    .instruction(instruction), .Run(Run), .busy(busy), .finished(finished), .err(err),
    .err_code(err_code), .pc(pc), .prog_len(prog_len), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   start_cyc = 0;
  int   dly[DEPTH];
  int   abort_idx = -1;
  int   issue_idx = 0;
  bit   force_done = 1'b0;

  // Reference model: program contents and the architectural status it implies.
  logic [15:0] m_prog[DEPTH];
  int m_len, m_pc, m_fin, m_err, m_code;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_len = 0; m_pc = 0; m_fin = 0; m_err = 0; m_code = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_len = 0; m_err = 0; m_fin = 0;
  endtask

  task automatic load_word(input logic [15:0] w);
    load_en = 1'b1;
    load_data = w;
    tick();
    load_en = 1'b0;
    if (m_len == DEPTH) begin
      m_err = 1; m_code = 3;
    end else begin
      m_prog[m_len] = w;
      m_len++;
    end
  endtask

  task automatic start_pulse();
    issue_idx = 0;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // Walk the program by the architectural rules and queue every instruction that must be issued.
  task automatic model_run();
    exp_t e;
    if (m_err != 0) return;
    if (m_len == 0) begin
      m_fin = 1;
      return;
    end
    m_fin = 0;
    for (int i = 0; i < m_len; i++) begin
      m_pc = i;
      if (m_prog[i][15]) begin
        m_err = 1; m_code = 1;
        break;
      end
      e.instr   = m_prog[i];
      e.hi_len  = 8'((dly[i] == 0) ? TIMEOUT : dly[i]);
      e.first   = (i == 0);
      e.chk_len = 1'b1;
      exp_q.push_back(e);
      if (i == abort_idx) break;
      if (dly[i] == 0) begin
        m_err = 1; m_code = 2;
        break;
      end
      if (i == m_len - 1) m_fin = 1;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_finished"}, int'(finished), m_fin);
    check({tag, "_err"}, int'(err), m_err);
    if (m_err != 0) check({tag, "_err_code"}, int'(err_code), m_code);
    check({tag, "_pc"}, int'(pc), m_pc);
    check({tag, "_prog_len"}, int'(prog_len), m_len);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_prog(input string tag);
    int n;
    model_run();
    start_pulse();
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_run_ends"}, int'(busy), 0);
    repeat (STEP_WAIT + 3) tick();
    check_status(tag);
  endtask

  // ---------------- control-unit responder ----------------
  initial begin
    int  r_idx = 0;
    int  r_hi = 0;
    logic rp_prev = 1'b0;
    Done = 1'b0;
    abort = 1'b0;
    forever begin
      @(negedge clock);
      if (Run && !rp_prev) begin
        r_idx = issue_idx;
        issue_idx++;
        r_hi = 1;
      end else if (Run) begin
        r_hi++;
      end
      rp_prev = Run;
      Done  = (Run && r_idx < DEPTH && dly[r_idx] != 0 && r_hi == dly[r_idx]) || force_done;
      abort = Done && Run && (r_idx == abort_idx);
    end
  end

`ifdef INSTR_ISSUER_STEP_EN
  initial begin
    logic sp_prev = 1'b0;
    step = 1'b0;
    forever begin
      @(negedge clock);
      if (!Run && sp_prev) begin
        repeat (STEP_WAIT - 1) @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
      end
      sp_prev = Run;
    end
  end
`endif

  // ---------------- monitor: pops on every Run assertion ----------------
  initial begin
    exp_t cur;
    bit   have_cur = 1'b0;
    int   hi_cnt = 0;
    int   last_hi = 0;
    logic mon_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (Run && !mon_prev) begin
        hi_cnt = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_run", 1, 0);
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          check("issued_instr", int'(instruction), int'(cur.instr));
          if (cur.first) check("start_to_run", cyc - start_cyc, 2);
          else           check("run_gap", cyc - last_hi, GAP);
        end
      end else if (Run) begin
        hi_cnt++;
        if (have_cur) check("instr_stable", int'(instruction), int'(cur.instr));
      end else if (mon_prev) begin
        last_hi = cyc - 1;
        if (have_cur && cur.chk_len) check("run_len", hi_cnt, int'(cur.hi_len));
        have_cur = 1'b0;
      end
      mon_prev = Run;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) dly[i] = 1;
    tick(); tick();
    Rest = 1'b0;
    model_reset();
    check("rst_instruction", int'(instruction), 0);
    check("rst_run", int'(Run), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_finished", int'(finished), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_pc", int'(pc), 0);
    check("rst_prog_len", int'(prog_len), 0);
    check("rst_state", int'(dbg_state), 0);

    // Two-instruction program: mv R1,#5 then add R2,R1.
    load_word(16'h1205);
    load_word(16'h4409);
    dly[0] = 2; dly[1] = 4;
    run_prog("basic");

    // Done outside ISSUE changes nothing.
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick(); tick();
    check("stray_done_finished", int'(finished), 1);
    check("stray_done_pc", int'(pc), 1);
    check("stray_done_run", int'(Run), 0);

    // Illegal opcode, then a refused start, then clear.
    do_clear();
    load_word(16'h8000);
    run_prog("illegal");
    run_prog("refused");
    do_clear();
    check("clear_err", int'(err), 0);
    check("clear_len", int'(prog_len), 0);

    // No Done: timeout after TIMEOUT cycles of Run.
    load_word(16'h1205);
    dly[0] = 0;
    run_prog("timeout");

    // Overflow on the 17th write.
    do_clear();
    for (int i = 0; i < DEPTH; i++) load_word(16'($urandom) & 16'h7fff);
    check("full_len", int'(prog_len), DEPTH);
    check("full_err", int'(err), 0);
    load_word(16'h1234);
    check("ovf_len", int'(prog_len), DEPTH);
    check("ovf_err", int'(err), 1);
    check("ovf_code", int'(err_code), 3);
    run_prog("ovf_refused");

    // Abort coinciding with Done on the 2nd of 3 instructions.
    do_clear();
    load_word(16'h1205); load_word(16'h4409); load_word(16'h6209);
    dly[0] = 2; dly[1] = 3; dly[2] = 2;
    abort_idx = 1;
    run_prog("abort");
    abort_idx = -1;

    // Reset in the middle of ISSUE.
    do_clear();
    load_word(16'h0003);
    dly[0] = 0;
    e.instr = 16'h0003; e.hi_len = 8'd0; e.first = 1'b1; e.chk_len = 1'b0;
    exp_q.push_back(e);
    start_pulse();
    n = 0;
    while (!Run && n < 20) begin
      tick();
      n++;
    end
    check("rst_mid_run_seen", int'(Run), 1);
    tick(); tick();
    Rest = 1'b1;
    tick();
    model_reset();
    check("rstmid_instruction", int'(instruction), 0);
    check("rstmid_run", int'(Run), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_err", int'(err), 0);
    check("rstmid_pc", int'(pc), 0);
    check("rstmid_prog_len", int'(prog_len), 0);
    Rest = 1'b0;
    tick(); tick();
    check("rstmid_drained", exp_q.size(), 0);
    exp_q.delete();

    // Randomized programs.
    for (int it = 0; it < 30; it++) begin
      if (m_err == 0 && m_fin != 0 && m_len > 0 && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < DEPTH; i++)
          dly[i] = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      end else begin
        int len;
        do_clear();
        len = int'($urandom_range(0, DEPTH));
        for (int i = 0; i < len; i++) begin
          logic [15:0] w;
          w = 16'($urandom);
          w[15] = ($urandom_range(0, 19) == 0);
          load_word(w);
          dly[i] = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
        end
      end
      run_prog("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
